// File: rtl/bcd_updown_counter.sv
// ---------------------------------------------------------------------------
// bcd_updown_counter
//   Multi-digit packed-BCD counter with a programmable terminal value,
//   up/down direction, count enable, synchronous clear and parallel load.
//   The registered wrap pulse is intended to drive en of a cascaded
//   instance (e.g. seconds -> minutes -> hours).
//
//   Optional build macro: BCD_COUNTER_SAT_EN
//     defined   : saturating mode. An up step at/above limit forces
//                 count = limit, and a down step at 0 holds 0. wrap pulses
//                 on every blocked step.
//     undefined : wrap-around mode (up past limit -> 0, down past 0 -> limit).
//
// Parameters
//   DIGITS    number of BCD digits (1..8); count width is 4*DIGITS
//   RESET_VAL reset/clear value, packed BCD
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   clr       synchronous clear to RESET_VAL
//   en        count enable, one step per clock
//   up        1 = increment, 0 = decrement
//   load      synchronous parallel load request
//   load_val  packed BCD load value (digit 0 in [3:0])
//   limit     packed BCD terminal value (modulus-1)
//   count     registered packed BCD count
//   wrap      registered one-cycle pulse on a wrap (or blocked step)
//   at_limit  combinational count == sanitised limit
//   at_zero   combinational count == 0
//   load_err  registered one-cycle pulse when a load is rejected
// ---------------------------------------------------------------------------
module bcd_updown_counter #(
    parameter int                  DIGITS    = 2,
    parameter logic [4*DIGITS-1:0] RESET_VAL = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                en,
    input  logic                up,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic [4*DIGITS-1:0] limit,
    output logic [4*DIGITS-1:0] count,
    output logic                wrap,
    output logic                at_limit,
    output logic                at_zero,
    output logic                load_err
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0]      lim_s;
    logic [W-1:0]      cnt_inc;
    logic [W-1:0]      cnt_dec;
    logic [DIGITS-1:0] carry;
    logic [DIGITS-1:0] borrow;
    logic [DIGITS-1:0] ld_dig_ok;
    logic              load_ok;

    logic [W-1:0]      next_count;
    logic              next_wrap;
    logic              next_err;

    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    // Per-digit datapath: limit sanitising, load-value validity and the
    // ripple increment/decrement chains. The whole ripple settles in one cycle.
    genvar i;
    generate
        for (i = 0; i < DIGITS; i++) begin : g_digit
            logic [3:0] c_d;
            logic [3:0] l_d;
            assign c_d = count[4*i +: 4];
            assign l_d = limit[4*i +: 4];

            assign lim_s[4*i +: 4] = (l_d > 4'd9) ? 4'd9 : l_d;
            assign ld_dig_ok[i]    = (load_val[4*i +: 4] <= 4'd9);

            assign cnt_inc[4*i +: 4] = !carry[i]     ? c_d  :
                                       (c_d == 4'd9) ? 4'd0 : c_d + 4'd1;
            assign cnt_dec[4*i +: 4] = !borrow[i]    ? c_d  :
                                       (c_d == 4'd0) ? 4'd9 : c_d - 4'd1;

            if (i < DIGITS - 1) begin : g_chain
                assign carry[i+1]  = carry[i]  && (c_d == 4'd9);
                assign borrow[i+1] = borrow[i] && (c_d == 4'd0);
            end
        end
    endgenerate

    // Valid packed BCD orders the same as plain binary, so the magnitude
    // compares below can use the packed words directly.
    assign load_ok = (&ld_dig_ok) && (load_val <= lim_s);

    always_comb begin
        next_count = count;
        next_wrap  = 1'b0;
        next_err   = 1'b0;
        if (clr) begin
            next_count = RESET_VAL;
        end else if (load) begin
            if (load_ok) next_count = load_val;
            else         next_err   = 1'b1;
        end else if (en) begin
            if (up) begin
                // >= also catches a limit lowered below the current count
                if (count >= lim_s) begin
`ifdef BCD_COUNTER_SAT_EN
                    next_count = lim_s;
`else
                    next_count = '0;
`endif
                    next_wrap  = 1'b1;
                end else begin
                    next_count = cnt_inc;
                end
            end else begin
                if (count == '0) begin
`ifndef BCD_COUNTER_SAT_EN
                    next_count = lim_s;
`endif
                    next_wrap  = 1'b1;
                end else begin
                    // above-limit counts just decrement; no clamp
                    next_count = cnt_dec;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= RESET_VAL;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            count    <= next_count;
            wrap     <= next_wrap;
            load_err <= next_err;
        end
    end

    assign at_limit = (count == lim_s);
    assign at_zero  = (count == '0);

endmodule

// File: tb/tb_bcd_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_updown_counter
//   Self-checking bench for bcd_updown_counter. Two instances run side by
//   side from shared controls: a 2-digit one (RESET_VAL 0) and a 3-digit
//   one (RESET_VAL 005). An integer-arithmetic model predicts both.
//   Honours BCD_COUNTER_SAT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_bcd_updown_counter;

`ifdef BCD_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam logic [31:0] RV2 = 32'h000;
    localparam logic [31:0] RV3 = 32'h005;

    logic        clk = 1'b0;
    logic        rst, clr, en, up, load;
    logic [11:0] ld_val, lim;

    logic [7:0]  cnt2;
    logic        wrap2, atl2, atz2, lerr2;
    logic [11:0] cnt3;
    logic        wrap3, atl3, atz3, lerr3;

    int tests = 0;
    int fails = 0;

    // model state
    logic [31:0] e2, e3;
    bit          ew2, ee2, ew3, ee3;

    always #5 clk = ~clk;

    bcd_updown_counter #(.DIGITS(2), .RESET_VAL(8'h00)) dut2 (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .up(up), .load(load),
        .load_val(ld_val[7:0]), .limit(lim[7:0]), .count(cnt2), .wrap(wrap2),
        .at_limit(atl2), .at_zero(atz2), .load_err(lerr2));

    bcd_updown_counter #(.DIGITS(3), .RESET_VAL(12'h005)) dut3 (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .up(up), .load(load),
        .load_val(ld_val), .limit(lim), .count(cnt3), .wrap(wrap3),
        .at_limit(atl3), .at_zero(atz3), .load_err(lerr3));

    // decimal value of nd BCD digits, digits above 9 read as 9
    function automatic int b2i(input logic [31:0] v, input int nd);
        int r = 0;
        for (int k = nd - 1; k >= 0; k--) begin
            int d = int'(v[4*k +: 4]);
            if (d > 9) d = 9;
            r = r * 10 + d;
        end
        return r;
    endfunction

    function automatic logic [31:0] i2b(input int x, input int nd);
        logic [31:0] r = '0;
        int          y = x;
        for (int k = 0; k < nd; k++) begin
            r[4*k +: 4] = 4'(y % 10);
            y = y / 10;
        end
        return r;
    endfunction

    function automatic bit bcd_ok(input logic [31:0] v, input int nd);
        for (int k = 0; k < nd; k++)
            if (v[4*k +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    // next-state rule from the behavioural description, in decimal
    task automatic model(input int nd, input logic [31:0] rv,
                         inout logic [31:0] c, output bit w, output bit e);
        int L = b2i({20'h0, lim}, nd);
        int v = b2i(c, nd);
        logic [31:0] lv = {20'h0, ld_val} & ((32'h1 << (4 * nd)) - 1);
        w = 1'b0;
        e = 1'b0;
        if (clr) c = rv;
        else if (load) begin
            if (bcd_ok(lv, nd) && b2i(lv, nd) <= L) c = lv;
            else e = 1'b1;
        end else if (en) begin
            if (up) begin
                if (v >= L) begin
                    c = SAT ? i2b(L, nd) : 32'h0;
                    w = 1'b1;
                end else c = i2b(v + 1, nd);
            end else begin
                if (v == 0) begin
                    c = SAT ? 32'h0 : i2b(L, nd);
                    w = 1'b1;
                end else c = i2b(v - 1, nd);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("cnt2",  {24'h0, cnt2}, e2);
        chk("wrap2", {31'h0, wrap2}, {31'h0, ew2});
        chk("lerr2", {31'h0, lerr2}, {31'h0, ee2});
        chk("atl2",  {31'h0, atl2}, {31'h0, b2i(e2, 2) == b2i({20'h0, lim}, 2)});
        chk("atz2",  {31'h0, atz2}, {31'h0, e2 == 32'h0});
        chk("cnt3",  {20'h0, cnt3}, e3);
        chk("wrap3", {31'h0, wrap3}, {31'h0, ew3});
        chk("lerr3", {31'h0, lerr3}, {31'h0, ee3});
        chk("atl3",  {31'h0, atl3}, {31'h0, b2i(e3, 3) == b2i({20'h0, lim}, 3)});
        chk("atz3",  {31'h0, atz3}, {31'h0, e3 == 32'h0});
    endtask

    // one clock: predict from the pre-edge inputs, then compare after the edge
    task automatic cyc();
        logic [31:0] n2 = e2, n3 = e3;
        bit w2, x2, w3, x3;
        model(2, RV2, n2, w2, x2);
        model(3, RV3, n3, w3, x3);
        @(posedge clk);
        #1;
        e2 = n2; ew2 = w2; ee2 = x2;
        e3 = n3; ew3 = w3; ee3 = x3;
        check_all();
    endtask

    initial begin
        logic [7:0] held;
        int         wraps;
        rst = 1'b1; clr = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0;
        ld_val = '0; lim = 12'h059;
        e2 = RV2; e3 = RV3; ew2 = 0; ee2 = 0; ew3 = 0; ee3 = 0;

        // reset state
        #3;
        check_all();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 00..59 seconds counter, 60-cycle period
        en = 1'b1; up = 1'b1;
        for (int k = 0; k < 59; k++) cyc();
        chk("sec_at_59", {24'h0, cnt2}, 32'h59);
        cyc();
`ifndef BCD_COUNTER_SAT_EN
        chk("sec_wrap_cnt", {24'h0, cnt2}, 32'h00);
        chk("sec_wrap_pulse", {31'h0, wrap2}, 32'h1);
        cyc();
        chk("sec_after_wrap", {24'h0, cnt2}, 32'h01);
        chk("sec_wrap_drop", {31'h0, wrap2}, 32'h0);
`endif

        // hours: load 19, five up steps, then one down step
        lim = 12'h023; load = 1'b1; ld_val = 12'h019;
        cyc();
        load = 1'b0;
        chk("hr_load", {24'h0, cnt2}, 32'h19);
        for (int k = 0; k < 4; k++) cyc();
        chk("hr_23", {24'h0, cnt2}, 32'h23);
        cyc();
`ifndef BCD_COUNTER_SAT_EN
        chk("hr_wrap_cnt", {24'h0, cnt2}, 32'h00);
        chk("hr_wrap", {31'h0, wrap2}, 32'h1);
        up = 1'b0;
        cyc();
        chk("hr_down_wrap_cnt", {24'h0, cnt2}, 32'h23);
        chk("hr_down_wrap", {31'h0, wrap2}, 32'h1);
`else
        up = 1'b0;
        cyc();
`endif

        // 3-digit double carry and borrow
        lim = 12'h999; load = 1'b1; ld_val = 12'h099;
        cyc();
        load = 1'b0; up = 1'b1;
        cyc();
        chk("d3_carry", {20'h0, cnt3}, 32'h100);
        up = 1'b0;
        cyc();
        chk("d3_borrow", {20'h0, cnt3}, 32'h099);

        // rejected loads, then clr wins over load and en
        en = 1'b0; lim = 12'h059; load = 1'b1; ld_val = 12'h01A;
        held = cnt2;
        cyc();
        chk("ld_bad_digit_err", {31'h0, lerr2}, 32'h1);
        chk("ld_bad_digit_hold", {24'h0, cnt2}, {24'h0, held});
        ld_val = 12'h070;
        cyc();
        chk("ld_over_lim_err", {31'h0, lerr2}, 32'h1);
        chk("ld_over_lim_hold", {24'h0, cnt2}, {24'h0, held});
        clr = 1'b1; en = 1'b1; ld_val = 12'h012;
        cyc();
        chk("clr_prio_cnt", {24'h0, cnt2}, 32'h00);
        chk("clr_prio_cnt3", {20'h0, cnt3}, 32'h005);
        chk("clr_prio_err", {31'h0, lerr2}, 32'h0);
        clr = 1'b0;

        // limit lowered under the current count
        ld_val = 12'h045;
        cyc();
        load = 1'b0; lim = 12'h030; up = 1'b1;
        cyc();
`ifndef BCD_COUNTER_SAT_EN
        chk("lim_lowered", {24'h0, cnt2}, 32'h00);
`else
        chk("lim_lowered", {24'h0, cnt2}, 32'h30);
`endif
        chk("lim_lowered_wrap", {31'h0, wrap2}, 32'h1);

        // random traffic, including illegal limit digits
        for (int k = 0; k < 400; k++) begin
            clr    = ($urandom_range(0, 31) == 0);
            load   = ($urandom_range(0, 15) == 0);
            en     = ($urandom_range(0, 7) != 0);
            up     = ($urandom_range(0, 3) != 0);
            ld_val = 12'($urandom);
            if ($urandom_range(0, 15) == 0) lim = 12'($urandom);
            cyc();
        end

        // asynchronous reset in the middle of counting
        clr = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1; lim = 12'h059;
        for (int k = 0; k < 3; k++) cyc();
        #2 rst = 1'b1;
        #1;
        chk("async_rst2", {24'h0, cnt2}, 32'h00);
        chk("async_rst3", {20'h0, cnt3}, 32'h005);
        @(negedge clk);
        rst = 1'b0;
        e2 = RV2; e3 = RV3; ew2 = 0; ee2 = 0; ew3 = 0; ee3 = 0;
        cyc();
        chk("rst_resume", {24'h0, cnt2}, 32'h01);

`ifdef BCD_COUNTER_SAT_EN
        // saturation at both bounds
        clr = 1'b1;
        cyc();
        clr = 1'b0; lim = 12'h005; up = 1'b1; wraps = 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            wraps += int'(wrap2);
        end
        chk("sat_hi_cnt", {24'h0, cnt2}, 32'h05);
        chk("sat_hi_wraps", wraps, 3);
        clr = 1'b1;
        cyc();
        clr = 1'b0; up = 1'b0;
        cyc();
        chk("sat_lo_cnt", {24'h0, cnt2}, 32'h00);
        chk("sat_lo_wrap", {31'h0, wrap2}, 32'h1);
`else
        wraps = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
